qtable_bank_mem: RTL and testbench

Parametrised, banked Q-table store for the traffic-light Q-learning accelerator. It replaces the ad-hoc four-RAM behavioural model with a synthesizable block that has:
- N_BANK road banks;
- a byte-enabled write port per bank;
- a shared registered read port;
- write-to-read forwarding;
- a hardware clear sequencer.

It sits between the accelerator's rd_addr/wr_addr/D_new/wen_bram* interface and the BRAM, and feeds D_road0..N back.

---
 rtl/qtable_pkg.sv | 35 +++
 rtl/qtable_bank.sv | 60 ++++++
 rtl/qtable_bank_mem.sv | 137 +++++++++++++
 tb/tb_qtable_bank_mem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qtable_pkg.sv
// Shared sizing helpers and sweep state type for the banked Q-table store.
package qtable_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } sweep_state_e;

  function automatic int calc_n_level(input int l_width);
    return 2 ** (l_width / 2);
  endfunction

  function automatic int calc_s_width(input int l_width);
    return 2 * l_width;
  endfunction

  function automatic int calc_d_width(input int q_width, input int l_width);
    return q_width * calc_n_level(l_width);
  endfunction

  function automatic int calc_depth(input int l_width);
    return 2 ** calc_s_width(l_width);
  endfunction

  // Address bits below the word index (log2 of the bytes per word).
  function automatic int calc_byte_shift(input int q_width, input int l_width);
    return $clog2(calc_d_width(q_width, l_width) / 8);
  endfunction

  // LSB of bank b inside a flat vector made of w-bit bank slices.
  function automatic int bank_lsb(input int b, input int w);
    return b * w;
  endfunction

endpackage

// File: rtl/qtable_bank.sv
// One Q-table bank: DEPTH x D_WIDTH RAM, byte write enables, registered read
// with per-byte write-first forwarding and a force-zero read used during clear.
module qtable_bank #(
  parameter int D_WIDTH = 64,
  parameter int S_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [D_WIDTH/8-1:0] wbe,
  input  logic [S_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic               rzero,
  input  logic [S_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** S_WIDTH;
  localparam int NB    = D_WIDTH / 8;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && wbe[i]) begin
        mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Enabled lanes of a same-index write replace the stored bytes on the read path.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (rzero) begin
        rdata_d = '0;
      end else begin
        rdata_d = mem_q[raddr];
        for (int i = 0; i < NB; i++) begin
          if (we && wbe[i] && (waddr == raddr)) begin
            rdata_d[8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/qtable_bank_mem.sv
// Banked Q-table store with shared registered read, byte-enabled writes and a
// zeroing clear sweep. Optional saturating write counter under QTABLE_WRCNT_EN.
module qtable_bank_mem
  import qtable_pkg::*;
#(
  parameter int N_BANK     = 4,
  parameter int L_WIDTH    = 4,
  parameter int Q_WIDTH    = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int CTR_WIDTH  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clear,
  input  logic                                          rd_en,
  input  logic [ADDR_WIDTH-1:0]                         rd_addr,
  output logic [N_BANK*calc_d_width(Q_WIDTH,L_WIDTH)-1:0] rd_data,
  output logic                                          rd_valid,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr,
  input  logic [calc_d_width(Q_WIDTH,L_WIDTH)-1:0]      wr_data,
  input  logic [N_BANK*calc_d_width(Q_WIDTH,L_WIDTH)/8-1:0] wr_be,
`ifdef QTABLE_WRCNT_EN
  output logic [CTR_WIDTH-1:0]                          wr_count,
`endif
  output logic                                          busy
);

  localparam int D_WIDTH    = calc_d_width(Q_WIDTH, L_WIDTH);
  localparam int S_WIDTH    = calc_s_width(L_WIDTH);
  localparam int BYTE_SHIFT = calc_byte_shift(Q_WIDTH, L_WIDTH);
  localparam int NB         = D_WIDTH / 8;

  sweep_state_e state_d, state_q;
  logic [S_WIDTH-1:0] idx_d, idx_q;
  logic rd_valid_d, rd_valid_q;
  logic [S_WIDTH-1:0] rd_idx, wr_idx;
  logic wr_ok, wr_accept;

  assign rd_idx    = rd_addr[BYTE_SHIFT +: S_WIDTH];
  assign wr_idx    = wr_addr[BYTE_SHIFT +: S_WIDTH];
  assign busy      = (state_q == SWEEP);
  assign wr_ok     = !busy && !clear;
  assign wr_accept = wr_ok && (|wr_be);

  // Upper address bits alias (index wraps modulo DEPTH); byte-offset bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[ADDR_WIDTH-1:BYTE_SHIFT+S_WIDTH], rd_addr[BYTE_SHIFT-1:0],
                              wr_addr[ADDR_WIDTH-1:BYTE_SHIFT+S_WIDTH], wr_addr[BYTE_SHIFT-1:0]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_valid_d = rd_en;
    if (clear) begin
      state_d = SWEEP;
      idx_d   = '0;
    end else if (state_q == SWEEP) begin
      idx_d = idx_q + S_WIDTH'(1);
      if (idx_q == '1) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SWEEP;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;

  // While sweeping, every bank's write port is stolen to zero the sweep index.
  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [NB-1:0]      be_slice;
    logic               bank_we;
    logic [NB-1:0]      bank_be;
    logic [S_WIDTH-1:0] bank_waddr;
    logic [D_WIDTH-1:0] bank_wdata;

    assign be_slice   = wr_be[bank_lsb(b, NB) +: NB];
    assign bank_we    = busy ? 1'b1 : (wr_ok && (|be_slice));
    assign bank_be    = busy ? '1 : be_slice;
    assign bank_waddr = busy ? idx_q : wr_idx;
    assign bank_wdata = busy ? '0 : wr_data;

    qtable_bank #(
      .D_WIDTH(D_WIDTH),
      .S_WIDTH(S_WIDTH)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (bank_we),
      .wbe  (bank_be),
      .waddr(bank_waddr),
      .wdata(bank_wdata),
      .re   (rd_en),
      .rzero(busy),
      .raddr(rd_idx),
      .rdata(rd_data[bank_lsb(b, D_WIDTH) +: D_WIDTH])
    );
  end

`ifdef QTABLE_WRCNT_EN
  logic [CTR_WIDTH-1:0] wr_count_d, wr_count_q;

  always_comb begin
    wr_count_d = wr_count_q;
    if (clear) begin
      wr_count_d = '0;
    end else if (wr_accept && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`else
  localparam int UNUSED_CTR_WIDTH = CTR_WIDTH;
  logic unused_wr_accept;
  assign unused_wr_accept = wr_accept;
`endif

endmodule

// File: tb/tb_qtable_bank_mem.sv
// Directed bench for qtable_bank_mem at default sizes (DEPTH=256, 4 banks of 64 bits).
module tb_qtable_bank_mem;

  localparam int RD_W = 256;
  localparam int D_W  = 64;
  localparam int BE_W = 32;
`ifdef QTABLE_WRCNT_EN
  localparam int CTR_W = 4;
`else
  localparam int CTR_W = 16;
`endif

  logic            clk;
  logic            rst;
  logic            clear;
  logic            rd_en;
  logic [31:0]     rd_addr;
  logic [RD_W-1:0] rd_data;
  logic            rd_valid;
  logic [31:0]     wr_addr;
  logic [D_W-1:0]  wr_data;
  logic [BE_W-1:0] wr_be;
  logic            busy;
`ifdef QTABLE_WRCNT_EN
  logic [CTR_W-1:0] wr_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int n;
  int m;
  logic [RD_W-1:0] exp_b1;

  qtable_bank_mem #(
    .CTR_WIDTH(CTR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
`ifdef QTABLE_WRCNT_EN
    .wr_count(wr_count),
`endif
    .busy    (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RD_W-1:0] got, input logic [RD_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_be = '0;
    clear = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    tick();
    tick();
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_busy", busy, 1);

    rst = 1'b0;
    wait_ready(n);
    check("sweep_len", n, 256);

    do_read(32'h7F8);
    check("rd_top_valid", rd_valid, 1);
    check("rd_top_data", rd_data, 0);
    tick();
    check("idle_valid", rd_valid, 0);

    // bank1-only write
    wr_addr = 32'h10;
    wr_data = 64'h1111_2222_3333_4444;
    wr_be   = 32'h0000_FF00;
    tick();
    idle();
    do_read(32'h10);
    exp_b1 = {64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'h0};
    check("bank1_write", rd_data, exp_b1);
    tick();
    check("hold_data", rd_data, exp_b1);
    check("hold_valid", rd_valid, 0);

    // forwarding, whole-lane then mixed old/new bytes
    wr_addr = 32'h28;
    wr_data = 64'hDEAD_BEEF_CAFE_ABCD;
    wr_be   = 32'h03;
    rd_en   = 1'b1;
    rd_addr = 32'h28;
    tick();
    idle();
    check("fwd_new", rd_data, {192'h0, 64'hABCD});

    wr_addr = 32'h28;
    wr_data = 64'h1111_2222_3333_4444;
    wr_be   = 32'h0C;
    rd_en   = 1'b1;
    rd_addr = 32'h28;
    tick();
    idle();
    check("fwd_mixed", rd_data, {192'h0, 64'h3333_ABCD});

    // all banks, one byte each, same cycle
    wr_addr = 32'h38;
    wr_data = 64'h8877_6655_4433_2211;
    wr_be   = 32'h0804_0201;
    tick();
    idle();
    do_read(32'h38);
    check("four_bank", rd_data, {64'h4400_0000, 64'h0033_0000, 64'h2200, 64'h11});

    // write idx 8 while reading idx 2
    wr_addr = 32'h40;
    wr_data = 64'hA5A5_5A5A_0F0F_F0F0;
    wr_be   = 32'hFFFF_FFFF;
    rd_en   = 1'b1;
    rd_addr = 32'h10;
    tick();
    idle();
    check("rw_indep", rd_data, exp_b1);
    do_read(32'h40);
    check("all_banks", rd_data, {4{64'hA5A5_5A5A_0F0F_F0F0}});
    do_read(32'h810);
    check("addr_wrap", rd_data, exp_b1);
`ifdef QTABLE_WRCNT_EN
    check("cnt_five", wr_count, 5);
`endif

    // clear, then restart it at sweep index 100
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", busy, 1);
    repeat (100) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    wr_addr = 32'h10;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_be   = 32'h0000_FF00;
    rd_en   = 1'b1;
    rd_addr = 32'h10;
    tick();
    idle();
    check("busy_rd_valid", rd_valid, 1);
    check("busy_rd_data", rd_data, 0);
    wait_ready(m);
    check("restart_len", 11 + m, 256);
    do_read(32'h10);
    check("drop_wr", rd_data, 0);
`ifdef QTABLE_WRCNT_EN
    check("cnt_clear", wr_count, 0);
    wr_addr = 32'h50;
    wr_data = 64'h1;
    wr_be   = 32'h1;
    repeat (20) tick();
    idle();
    check("cnt_sat", wr_count, 15);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cnt_clr2", wr_count, 0);
    wait_ready(m);
`endif

    // reset asserted mid-sweep with a read pending
    wr_addr = 32'h18;
    wr_data = 64'h0123_4567_89AB_CDEF;
    wr_be   = 32'hFFFF_FFFF;
    tick();
    idle();
    do_read(32'h18);
    check("pre_rst", rd_data, {4{64'h0123_4567_89AB_CDEF}});
`ifdef QTABLE_WRCNT_EN
    check("cnt_one", wr_count, 1);
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (40) tick();
    rd_en   = 1'b1;
    rd_addr = 32'h18;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_busy", busy, 1);
`ifdef QTABLE_WRCNT_EN
    check("mid_rst_cnt", wr_count, 0);
`endif
    rd_en = 1'b0;
    tick();
    tick();
    check("rst_hold_valid", rd_valid, 0);
    rst = 1'b0;
    wait_ready(n);
    check("sweep_len2", n, 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
